vfifo_wr_arbiter: RTL and testbench

Two-requester write scheduler in front of the ddrvfifo s_axis slave port. It grants one source at a time by round-robin and streams that source's words as one AXI-Stream packet on the matching tdest channel. Packets end with tlast after BURSTLEN beats, or early when the granted source goes idle for FLUSH_TIMEOUT cycles. A one-word lookahead hold register allows the last available word to carry tlast without padding.

---
 rtl/vfifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_vfifo_wr_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfifo_wr_arbiter.sv
// vfifo_wr_arbiter
//   Two-source write scheduler feeding the ddrvfifo s_axis slave port.
//   Sources are granted one at a time by round-robin. The granted source's
//   words go out as one AXI-Stream packet whose tdest is the source index.
//   A packet closes with tlast after BURSTLEN beats, or earlier once the
//   granted source has been idle for FLUSH_TIMEOUT cycles. A one-word hold
//   register sits in front of the output register, so the last available
//   word can carry tlast without any padding beat.
//
// Ports
//   BUS_CLK, BUS_RST_N       clock, asynchronous active-low reset
//   ENABLE                   permits new grants (a running packet always completes)
//   CHx_DATA/VALID/READY     source x word, word present, word consumed
//   vfifo_s2mm_channel_full  per-channel full flag; only gates new grants
//   m_axis_*                 AXI-Stream master towards ddrvfifo s_axis
//   BUSY                     high whenever a packet is being built or drained
//   PKT_CNT0/1               completed packets per channel (16-bit, wrapping)

module vfifo_wr_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURSTLEN      = 128,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] CH0_DATA,
  input  logic                  CH0_VALID,
  output logic                  CH0_READY,
  input  logic [DATA_WIDTH-1:0] CH1_DATA,
  input  logic                  CH1_VALID,
  output logic                  CH1_READY,
  input  logic [1:0]            vfifo_s2mm_channel_full,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tdest,
  output logic                  BUSY,
  output logic [15:0]           PKT_CNT0,
  output logic [15:0]           PKT_CNT1
);

  localparam int BW = $clog2(BURSTLEN + 1);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURSTLEN);
  localparam logic [TW-1:0] IDLE_MAX = TW'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  grant;
  logic                  last_grant;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_valid;
  logic [BW-1:0]         beat_cnt;
  logic [TW-1:0]         idle_cnt;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_dest;
  logic [15:0]           pkt_cnt0;
  logic [15:0]           pkt_cnt1;

  logic                  elig0, elig1, grant_req, grant_pick;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  out_free, close_due;
  logic                  accept, do_close;

  // Arbitration: on a tie the source that did not have the previous packet wins.
  assign elig0      = ENABLE & CH0_VALID & ~vfifo_s2mm_channel_full[0];
  assign elig1      = ENABLE & CH1_VALID & ~vfifo_s2mm_channel_full[1];
  assign grant_req  = elig0 | elig1;
  assign grant_pick = (elig0 & elig1) ? ~last_grant : elig1;

  assign src_valid = grant ? CH1_VALID : CH0_VALID;
  assign src_data  = grant ? CH1_DATA  : CH0_DATA;

  assign out_free  = ~out_valid | m_axis_tready;
  // The hold register carries the packet's final word once the beat limit
  // is reached or the source has stalled long enough.
  assign close_due = hold_valid & ((beat_cnt == BEAT_MAX) | (idle_cnt == IDLE_MAX));

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    do_close   = 1'b0;
    CH0_READY  = 1'b0;
    CH1_READY  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_req) begin
          state_next = PKT;
        end
      end
      PKT: begin
        // Closing takes priority over accepting; while close_due holds and the
        // output is blocked, hold_valid already keeps READY low.
        do_close  = close_due & out_free;
        accept    = src_valid & ~close_due & (~hold_valid | out_free);
        CH0_READY = accept & ~grant;
        CH1_READY = accept & grant;
        if (do_close) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid & m_axis_tready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_dest   <= 1'b0;
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_req) begin
            grant    <= grant_pick;
            out_dest <= grant_pick;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        PKT: begin
          if (accept) begin
            hold_data  <= src_data;
            hold_valid <= 1'b1;
            beat_cnt   <= beat_cnt + BW'(1);
            idle_cnt   <= '0;
          end else if (hold_valid && (idle_cnt != IDLE_MAX)) begin
            idle_cnt <= idle_cnt + TW'(1);
          end

          if (do_close) begin
            out_valid  <= 1'b1;
            out_data   <= hold_data;
            out_last   <= 1'b1;
            hold_valid <= 1'b0;
          end else if (accept && hold_valid) begin
            // A new word displaces the held one into the output register.
            out_valid <= 1'b1;
            out_data  <= hold_data;
            out_last  <= 1'b0;
          end else if (m_axis_tready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_valid && m_axis_tready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            last_grant <= grant;
            if (grant) begin
              pkt_cnt1 <= pkt_cnt1 + 16'd1;
            end else begin
              pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign m_axis_tdest  = out_dest;
  assign BUSY          = (state != IDLE);
  assign PKT_CNT0      = pkt_cnt0;
  assign PKT_CNT1      = pkt_cnt1;

endmodule

// File: tb/tb_vfifo_wr_arbiter.sv
// Testbench for vfifo_wr_arbiter: queue-fed sources, a stream monitor that
// records every output beat, and one task per scenario checking the
// recorded stream against packetization rules computed in the bench.

module tb_vfifo_wr_arbiter;

  localparam int DW = 32;
  localparam int BL = 128;
  localparam int FT = 64;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST_N = 1'b1;
  logic          ENABLE = 1'b0;
  logic [DW-1:0] CH0_DATA = '0;
  logic          CH0_VALID = 1'b0;
  logic          CH0_READY;
  logic [DW-1:0] CH1_DATA = '0;
  logic          CH1_VALID = 1'b0;
  logic          CH1_READY;
  logic [1:0]    full = 2'b00;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tdest;
  logic          BUSY;
  logic [15:0]   PKT_CNT0, PKT_CNT1;

  always #5 BUS_CLK = ~BUS_CLK;

  vfifo_wr_arbiter #(.DATA_WIDTH(DW), .BURSTLEN(BL), .FLUSH_TIMEOUT(FT)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE),
    .CH0_DATA(CH0_DATA), .CH0_VALID(CH0_VALID), .CH0_READY(CH0_READY),
    .CH1_DATA(CH1_DATA), .CH1_VALID(CH1_VALID), .CH1_READY(CH1_READY),
    .vfifo_s2mm_channel_full(full),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .BUSY(BUSY), .PKT_CNT0(PKT_CNT0), .PKT_CNT1(PKT_CNT1)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          dest;
    int            cyc;
  } beat_t;

  beat_t         out_q[$];
  logic [DW-1:0] src0_q[$];
  logic [DW-1:0] src1_q[$];
  bit            rand_valid = 0;
  bit            rand_ready = 0;
  int            cyc = 0;
  int            acc_cyc0 = -1;
  int            acc_cyc1 = -1;
  int            n_checks = 0;
  int            n_pass = 0;

  // Source driver and output monitor. Handshakes are sampled mid-cycle;
  // inputs change 1 ns after the rising edge.
  initial begin : drive_monitor
    bit    h0, h1;
    beat_t b;
    forever begin
      @(negedge BUS_CLK);
      h0 = CH0_VALID && CH0_READY;
      h1 = CH1_VALID && CH1_READY;
      if (m_axis_tvalid && m_axis_tready) begin
        b.data = m_axis_tdata;
        b.last = m_axis_tlast;
        b.dest = m_axis_tdest;
        b.cyc  = cyc;
        out_q.push_back(b);
      end
      if (h0) acc_cyc0 = cyc;
      if (h1) acc_cyc1 = cyc;
      @(posedge BUS_CLK);
      cyc++;
      #1;
      if (h0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (h1 && src1_q.size() > 0) void'(src1_q.pop_front());
      CH0_VALID     = (src0_q.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
      CH0_DATA      = (src0_q.size() > 0) ? src0_q[0] : '0;
      CH1_VALID     = (src1_q.size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
      CH1_DATA      = (src1_q.size() > 0) ? src1_q[0] : '0;
      m_axis_tready = !rand_ready || ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, need completion", n_checks);
    $fatal(1);
  end

  task automatic hold_reset();
    @(posedge BUS_CLK);
    #2;
    BUS_RST_N  = 1'b0;
    rand_valid = 0;
    rand_ready = 0;
    full       = 2'b00;
    ENABLE     = 1'b1;
    src0_q.delete();
    src1_q.delete();
    #1;
    out_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge BUS_CLK);
    #2;
    BUS_RST_N = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge BUS_CLK);
      if (out_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
    #2;
  endtask

  function automatic logic [69:0] out_vec();
    return {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, BUSY,
            PKT_CNT0, PKT_CNT1, CH0_READY, CH1_READY};
  endfunction

  task automatic test_reset();
    hold_reset();
    n_checks++;
    if (out_vec() !== 70'd0) $display("FAIL reset_outputs: got %h, need 0", out_vec());
    else n_pass++;
    src0_q.push_back(32'h1);
    src1_q.push_back(32'h2);
    repeat (3) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (out_vec() !== 70'd0) $display("FAIL reset_held_valid: got %h, need 0", out_vec());
    else n_pass++;
  endtask

  task automatic test_stream_300();
    bit ok;
    bit exp_last;
    hold_reset();
    for (int i = 0; i < 300; i++) src0_q.push_back(32'(i));
    release_reset();
    wait_beats(300, 3000, ok);
    n_checks++;
    if (!ok) $display("FAIL s300_count: got %0d beats, need 300", out_q.size());
    else n_pass++;
    for (int i = 0; i < 300 && i < out_q.size(); i++) begin
      exp_last = (i % BL == BL - 1) || (i == 299);
      n_checks++;
      if (out_q[i].data !== 32'(i) || out_q[i].last !== exp_last || out_q[i].dest !== 1'b0) begin
        $display("FAIL s300_beat%0d: got data=%0d last=%b dest=%b, need data=%0d last=%b dest=0",
                 i, out_q[i].data, out_q[i].last, out_q[i].dest, i, exp_last);
        break;
      end else n_pass++;
    end
    if (out_q.size() >= 300) begin
      n_checks++;
      if (out_q[299].cyc - acc_cyc0 != FT + 2)
        $display("FAIL s300_flush_delay: got %0d cycles, need %0d", out_q[299].cyc - acc_cyc0, FT + 2);
      else n_pass++;
    end
    repeat (3) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (PKT_CNT0 !== 16'd3 || PKT_CNT1 !== 16'd0 || BUSY !== 1'b0)
      $display("FAIL s300_counts: got cnt0=%0d cnt1=%0d busy=%b, need 3 0 0", PKT_CNT0, PKT_CNT1, BUSY);
    else n_pass++;
  endtask

  task automatic test_alternate();
    bit            ok;
    int            k[2];
    int            pkt, pos;
    logic          ed;
    logic [DW-1:0] ev;
    hold_reset();
    for (int i = 0; i < 256; i++) begin
      src0_q.push_back({16'h0000, 8'h00, 8'(i)});
      src1_q.push_back({16'h0001, 8'h00, 8'(i)});
    end
    release_reset();
    wait_beats(512, 4000, ok);
    n_checks++;
    if (!ok) $display("FAIL alt_count: got %0d beats, need 512", out_q.size());
    else n_pass++;
    k[0] = 0; k[1] = 0;
    for (int i = 0; i < 512 && i < out_q.size(); i++) begin
      pkt = i / BL;
      pos = i % BL;
      ed  = 1'(pkt % 2);
      ev  = {15'h0000, ed, 8'h00, 8'(k[ed])};
      k[ed]++;
      n_checks++;
      if (out_q[i].dest !== ed || out_q[i].data !== ev || out_q[i].last !== (pos == BL - 1)) begin
        $display("FAIL alt_beat%0d: got dest=%b data=%h last=%b, need dest=%b data=%h last=%b",
                 i, out_q[i].dest, out_q[i].data, out_q[i].last, ed, ev, pos == BL - 1);
        break;
      end else n_pass++;
    end
    repeat (3) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (PKT_CNT0 !== 16'd2 || PKT_CNT1 !== 16'd2)
      $display("FAIL alt_counts: got cnt0=%0d cnt1=%0d, need 2 2", PKT_CNT0, PKT_CNT1);
    else n_pass++;
  endtask

  task automatic test_short_flush();
    bit            ok;
    logic [DW-1:0] w[5];
    hold_reset();
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      src0_q.push_back(w[i]);
    end
    release_reset();
    wait_beats(5, 400, ok);
    n_checks++;
    if (!ok) $display("FAIL short_count: got %0d beats, need 5", out_q.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i].data !== w[i] || out_q[i].last !== (i == 4) || out_q[i].dest !== 1'b0) begin
        $display("FAIL short_beat%0d: got data=%h last=%b dest=%b, need data=%h last=%b dest=0",
                 i, out_q[i].data, out_q[i].last, out_q[i].dest, w[i], i == 4);
        break;
      end else n_pass++;
    end
    if (out_q.size() >= 5) begin
      n_checks++;
      if (out_q[4].cyc - acc_cyc0 != FT + 2)
        $display("FAIL short_flush_delay: got %0d cycles, need %0d", out_q[4].cyc - acc_cyc0, FT + 2);
      else n_pass++;
    end
    repeat (3) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (PKT_CNT0 !== 16'd1) $display("FAIL short_cnt0: got %0d, need 1", PKT_CNT0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[BL];
    bit            stall;
    logic [DW-1:0] sd;
    logic          sl, sdst;
    hold_reset();
    rand_ready = 1;
    for (int i = 0; i < BL; i++) begin
      w[i] = $urandom;
      src0_q.push_back(w[i]);
    end
    release_reset();
    stall = 0;
    for (int c = 0; c < 4000 && out_q.size() < BL; c++) begin
      @(negedge BUS_CLK);
      if (stall) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sd || m_axis_tlast !== sl || m_axis_tdest !== sdst)
          $display("FAIL bp_stable: got v=%b d=%h l=%b t=%b, need v=1 d=%h l=%b t=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, sd, sl, sdst);
        else n_pass++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      sd    = m_axis_tdata;
      sl    = m_axis_tlast;
      sdst  = m_axis_tdest;
    end
    repeat (2) @(posedge BUS_CLK);
    #2;
    rand_ready = 0;
    n_checks++;
    if (out_q.size() != BL) $display("FAIL bp_count: got %0d beats, need %0d", out_q.size(), BL);
    else n_pass++;
    for (int i = 0; i < BL && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i].data !== w[i] || out_q[i].last !== (i == BL - 1)) begin
        $display("FAIL bp_beat%0d: got data=%h last=%b, need data=%h last=%b",
                 i, out_q[i].data, out_q[i].last, w[i], i == BL - 1);
        break;
      end else n_pass++;
    end
  endtask

  task automatic test_channel_full();
    bit ok;
    hold_reset();
    full = 2'b01;
    for (int i = 0; i < 20; i++) src0_q.push_back(32'hA00 + 32'(i));
    for (int i = 0; i < 5; i++) src1_q.push_back(32'hB00 + 32'(i));
    release_reset();
    wait_beats(5, 400, ok);
    n_checks++;
    if (!ok) $display("FAIL full_first_count: got %0d beats, need 5", out_q.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i].dest !== 1'b1 || out_q[i].data !== 32'hB00 + 32'(i) || out_q[i].last !== (i == 4)) begin
        $display("FAIL full_first_beat%0d: got dest=%b data=%h last=%b, need dest=1 data=%h last=%b",
                 i, out_q[i].dest, out_q[i].data, out_q[i].last, 32'hB00 + 32'(i), i == 4);
        break;
      end else n_pass++;
    end
    @(posedge BUS_CLK);
    #2;
    full = 2'b11;
    for (int i = 5; i < 10; i++) src1_q.push_back(32'hB00 + 32'(i));
    repeat (4) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL full_both_blocked: got busy=%b, need 0", BUSY);
    else n_pass++;
    full = 2'b00;
    wait_beats(30, 1000, ok);
    n_checks++;
    if (!ok) $display("FAIL full_rest_count: got %0d beats, need 30", out_q.size());
    else n_pass++;
    for (int i = 5; i < 30 && i < out_q.size(); i++) begin
      n_checks++;
      if (i < 25 ? (out_q[i].dest !== 1'b0 || out_q[i].data !== 32'hA00 + 32'(i - 5))
                 : (out_q[i].dest !== 1'b1 || out_q[i].data !== 32'hB00 + 32'(i - 20))) begin
        $display("FAIL full_rest_beat%0d: got dest=%b data=%h, need dest=%b",
                 i, out_q[i].dest, out_q[i].data, i >= 25);
        break;
      end else n_pass++;
    end
  endtask

  task automatic test_enable();
    bit ok;
    hold_reset();
    ENABLE = 1'b0;
    for (int i = 0; i < 10; i++) src0_q.push_back(32'h5000 + 32'(i));
    release_reset();
    repeat (20) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (BUSY !== 1'b0 || out_q.size() != 0)
      $display("FAIL en_off: got busy=%b beats=%0d, need 0 0", BUSY, out_q.size());
    else n_pass++;
    ENABLE = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge BUS_CLK);
      #2;
      if (BUSY) break;
    end
    ENABLE = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1) $display("FAIL en_grant: got busy=%b, need 1", BUSY);
    else n_pass++;
    wait_beats(10, 400, ok);
    n_checks++;
    if (!ok || out_q[9].last !== 1'b1 || out_q[9].data !== 32'h5009)
      $display("FAIL en_complete: got beats=%0d, need 10 with tlast on data 5009", out_q.size());
    else n_pass++;
    repeat (3) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (PKT_CNT0 !== 16'd1) $display("FAIL en_cnt0: got %0d, need 1", PKT_CNT0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    bit            ok;
    logic [DW-1:0] exp0[$];
    hold_reset();
    for (int i = 0; i < 200; i++) src0_q.push_back(32'(i));
    release_reset();
    wait_beats(60, 400, ok);
    n_checks++;
    if (!ok) $display("FAIL rmid_reach60: got %0d beats, need 60", out_q.size());
    else n_pass++;
    BUS_RST_N = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 70'd0) $display("FAIL rmid_outputs: got %h, need 0", out_vec());
    else n_pass++;
    out_q.delete();
    exp0 = src0_q;
    for (int i = 0; i < 200; i++) src1_q.push_back(32'h10000 + 32'(i));
    release_reset();
    wait_beats(256, 2000, ok);
    n_checks++;
    if (!ok) $display("FAIL rmid_count: got %0d beats, need 256", out_q.size());
    else n_pass++;
    for (int i = 0; i < 256 && i < out_q.size(); i++) begin
      n_checks++;
      if (i < BL ? (out_q[i].dest !== 1'b0 || out_q[i].data !== exp0[i] || out_q[i].last !== (i == BL - 1))
                 : (out_q[i].dest !== 1'b1 || out_q[i].data !== 32'h10000 + 32'(i - BL))) begin
        $display("FAIL rmid_beat%0d: got dest=%b data=%h last=%b, need dest=%b",
                 i, out_q[i].dest, out_q[i].data, out_q[i].last, i >= BL);
        break;
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    bit            ok;
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    int            idx[2];
    int            nlast[2];
    int            plen;
    logic          pdest;
    logic          d;
    logic [DW-1:0] ev;
    hold_reset();
    rand_valid = 1;
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      exp0.push_back($urandom);
      exp1.push_back($urandom);
    end
    src0_q = exp0;
    src1_q = exp1;
    release_reset();
    wait_beats(600, 20000, ok);
    repeat (3) @(posedge BUS_CLK);
    #2;
    n_checks++;
    if (!ok) $display("FAIL rnd_count: got %0d beats, need 600", out_q.size());
    else n_pass++;
    idx[0] = 0; idx[1] = 0; nlast[0] = 0; nlast[1] = 0;
    plen = 0; pdest = 1'b0;
    for (int i = 0; i < out_q.size(); i++) begin
      d = out_q[i].dest;
      n_checks++;
      if (plen > 0 && d !== pdest) begin
        $display("FAIL rnd_dest_beat%0d: got dest=%b, need %b", i, d, pdest);
        break;
      end
      if (idx[d] >= 300) begin
        $display("FAIL rnd_extra_beat%0d: got extra word on dest %b, need none", i, d);
        break;
      end
      ev = d ? exp1[idx[d]] : exp0[idx[d]];
      if (out_q[i].data !== ev) begin
        $display("FAIL rnd_data_beat%0d: got %h, need %h", i, out_q[i].data, ev);
        break;
      end
      idx[d]++;
      pdest = d;
      plen++;
      if (plen > BL) begin
        $display("FAIL rnd_len_beat%0d: got packet length %0d, need <= %0d", i, plen, BL);
        break;
      end
      n_pass++;
      if (out_q[i].last) begin
        nlast[d]++;
        plen = 0;
      end
    end
    n_checks++;
    if (idx[0] != 300 || idx[1] != 300 || plen != 0)
      $display("FAIL rnd_complete: got %0d/%0d words open=%0d, need 300/300 open=0", idx[0], idx[1], plen);
    else n_pass++;
    n_checks++;
    if (PKT_CNT0 !== 16'(nlast[0]) || PKT_CNT1 !== 16'(nlast[1]))
      $display("FAIL rnd_counts: got %0d %0d, need %0d %0d", PKT_CNT0, PKT_CNT1, nlast[0], nlast[1]);
    else n_pass++;
    rand_valid = 0;
    rand_ready = 0;
  endtask

  initial begin
    test_reset();
    test_stream_300();
    test_alternate();
    test_short_flush();
    test_backpressure();
    test_channel_full();
    test_enable();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
